// File: rtl/vend_pkg.sv
// Shared constants for the coin scheduler: coin codes, FSM encoding, change weights, price.
package vend_pkg;

  localparam logic [1:0] CoinInv = 2'b00;
  localparam logic [1:0] Coin1   = 2'b01;
  localparam logic [1:0] Coin2   = 2'b10;
  localparam logic [1:0] Coin5   = 2'b11;

  localparam logic [2:0] ChgW1 = 3'd1;
  localparam logic [2:0] ChgW2 = 3'd2;
  localparam logic [2:0] ChgW4 = 3'd4;

  localparam logic [3:0] Price = 4'd5;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StIssue  = 2'd1,
    StSample = 2'd2,
    StDisp   = 2'd3
  } state_e;

  function automatic logic [3:0] coin_value(input logic [1:0] code);
    case (code)
      Coin1:   coin_value = 4'd1;
      Coin2:   coin_value = 4'd2;
      Coin5:   coin_value = 4'd5;
      default: coin_value = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; the pointer flips to the other slot after every grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic ptr_q, ptr_d;

  always_comb begin
    gnt[0] = en & req[0] & (~req[1] | ~ptr_q);
    gnt[1] = en & req[1] & (~req[0] | ptr_q);
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt[0]) begin
      ptr_d = 1'b1;
    end else if (gnt[1]) begin
      ptr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/coin_sched.sv
// Arbitrates two coin slots into a vending FSM, shadows its credit to cross-check its
// soda/change responses, and forwards results to a dispenser over a valid/ready handshake.
module coin_sched #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s0_vld,
  input  logic             s1_vld,
  input  logic [1:0]       s0_coin,
  input  logic [1:0]       s1_coin,
  output logic             s0_rdy,
  output logic             s1_rdy,
  output logic             in1,
  output logic             in2,
  output logic             in5,
  input  logic             out1,
  input  logic             out2,
  input  logic             out2x2,
  input  logic             soda,
  output logic             disp_vld,
  input  logic             disp_rdy,
  output logic             disp_soda,
  output logic [2:0]       disp_chg,
  output logic [2:0]       credit,
  output logic [CNT_W-1:0] vend_cnt,
  output logic             err
);

  import vend_pkg::*;

  localparam logic [CNT_W-1:0] CntMax = '1;

  state_e           state_q, state_d;
  logic [1:0]       code_q;
  logic             soda_q;
  logic [2:0]       chg_q;
  logic [2:0]       credit_q;
  logic             err_q;
  logic [CNT_W-1:0] vend_cnt_q;

  logic [1:0] gnt;
  logic       arb_en;
  logic       granted;
  logic [1:0] sel_code;
  logic [2:0] cap_chg;
  logic [3:0] sum;
  logic       exp_soda;
  logic [2:0] exp_chg;
  logic       mismatch;

  // Grants only in IDLE, and never while reset holds the FSM there.
  assign arb_en   = (state_q == StIdle) & ~rst;
  assign granted  = |gnt;
  assign sel_code = gnt[1] ? s1_coin : s0_coin;

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req ({s1_vld, s0_vld}),
    .en  (arb_en),
    .gnt (gnt)
  );

  assign cap_chg  = (out1 ? ChgW1 : 3'd0) + (out2 ? ChgW2 : 3'd0) + (out2x2 ? ChgW4 : 3'd0);
  assign sum      = {1'b0, credit_q} + coin_value(code_q);
  assign exp_soda = (sum >= Price);
  assign exp_chg  = exp_soda ? 3'(sum - Price) : 3'd0;
  assign mismatch = (soda != exp_soda) | (cap_chg != exp_chg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        // An invalid code is consumed by the grant and simply dropped.
        if (granted) state_d = (sel_code == CoinInv) ? StIdle : StIssue;
      end
      StIssue:  state_d = StSample;
      StSample: state_d = (soda || (cap_chg != 3'd0)) ? StDisp : StIdle;
      StDisp: begin
        if (disp_rdy) state_d = StIdle;
      end
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    s0_rdy    = gnt[0];
    s1_rdy    = gnt[1];
    in1       = 1'b0;
    in2       = 1'b0;
    in5       = 1'b0;
    disp_vld  = 1'b0;
    disp_soda = 1'b0;
    disp_chg  = 3'd0;
    case (state_q)
      StIssue: begin
        in1 = (code_q == Coin1);
        in2 = (code_q == Coin2);
        in5 = (code_q == Coin5);
      end
      StDisp: begin
        disp_vld  = 1'b1;
        disp_soda = soda_q;
        disp_chg  = chg_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_q     <= CoinInv;
      soda_q     <= 1'b0;
      chg_q      <= 3'd0;
      credit_q   <= 3'd0;
      err_q      <= 1'b0;
      vend_cnt_q <= '0;
    end else begin
      if ((state_q == StIdle) && granted) code_q <= sel_code;
      if (state_q == StSample) begin
        soda_q   <= soda;
        chg_q    <= cap_chg;
        credit_q <= exp_soda ? 3'd0 : sum[2:0];
        if (mismatch) err_q <= 1'b1;
      end
      if ((state_q == StDisp) && disp_rdy && soda_q && (vend_cnt_q != CntMax)) begin
        vend_cnt_q <= vend_cnt_q + 1'b1;
      end
    end
  end

  assign credit   = credit_q;
  assign err      = err_q;
  assign vend_cnt = vend_cnt_q;

endmodule

// File: tb/tb_coin_sched.sv
// Self-checking bench for coin_sched: behavioural vending machine plus a transaction-level
// credit/count/error model; directed scenarios followed by randomized coin traffic.
module tb_coin_sched;

  localparam int CNT_W  = 8;
  localparam int MAXCNT = (1 << CNT_W) - 1;

  logic clk, rst;
  logic s0_vld, s1_vld, s0_rdy, s1_rdy;
  logic [1:0] s0_coin, s1_coin;
  logic in1, in2, in5;
  logic out1, out2, out2x2, soda;
  logic disp_vld, disp_rdy, disp_soda;
  logic [2:0] disp_chg, credit;
  logic [CNT_W-1:0] vend_cnt;
  logic err;

  int total, bad;
  int ref_credit, ref_cnt;
  bit ref_err;
  logic vm_fault, vm_clear;
  int vm_credit, vm_s, vm_c;

  coin_sched #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .s0_vld(s0_vld), .s1_vld(s1_vld), .s0_coin(s0_coin), .s1_coin(s1_coin),
    .s0_rdy(s0_rdy), .s1_rdy(s1_rdy),
    .in1(in1), .in2(in2), .in5(in5),
    .out1(out1), .out2(out2), .out2x2(out2x2), .soda(soda),
    .disp_vld(disp_vld), .disp_rdy(disp_rdy), .disp_soda(disp_soda), .disp_chg(disp_chg),
    .credit(credit), .vend_cnt(vend_cnt), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural vending machine: registered soda/change one cycle after a coin pulse.
  always @(posedge clk) begin
    out1 <= 1'b0; out2 <= 1'b0; out2x2 <= 1'b0; soda <= 1'b0;
    if (vm_clear) begin
      vm_credit <= 0;
    end else if (in1 || in2 || in5) begin
      vm_s = vm_credit + (in1 ? 1 : (in2 ? 2 : 5));
      if (vm_s >= 5) begin
        soda <= 1'b1; vm_c = vm_s - 5; vm_credit <= 0;
      end else begin
        vm_c = 0; vm_credit <= vm_s;
      end
      if (vm_fault) vm_c = 2;
      out1 <= vm_c[0]; out2 <= vm_c[1]; out2x2 <= vm_c[2];
    end
  end

  function automatic int coin_val(input logic [1:0] code);
    return (code == 2'b01) ? 1 : (code == 2'b10) ? 2 : (code == 2'b11) ? 5 : 0;
  endfunction

  // Shadow-credit rule applied to the bench's own reference state.
  function automatic void model_coin(input int val, output bit t_soda, output int t_chg);
    int s;
    s = ref_credit + val;
    if (s >= 5) begin t_soda = 1; t_chg = s - 5; ref_credit = 0; end
    else begin t_soda = 0; t_chg = 0; ref_credit = s; end
  endfunction

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1; vm_clear = 1; vm_fault = 0;
    s0_vld = 0; s1_vld = 0; s0_coin = 0; s1_coin = 0; disp_rdy = 0;
    @(posedge clk); #1;
    rst = 0; vm_clear = 0;
    ref_credit = 0; ref_cnt = 0; ref_err = 0;
  endtask

  task automatic run_coin(input int slot, input logic [1:0] code, input int stall);
    bit got, t_soda, disp;
    int t_chg, rep_chg;
    logic [2:0] exp_in;
    @(posedge clk); #1;
    if (slot == 0) begin s0_vld = 1; s0_coin = code; end
    else begin s1_vld = 1; s1_coin = code; end
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = (slot == 0) ? s0_rdy : s1_rdy;
    end
    total++;
    if (!got) begin
      bad++; $display("FAIL grant_wait slot=%0d rdy never seen, required within 20 cycles", slot);
      s0_vld = 0; s1_vld = 0;
      return;
    end
    total++;
    if (((slot == 0) ? s1_rdy : s0_rdy) !== 1'b0) begin
      bad++; $display("FAIL other_rdy slot=%0d other rdy=1, required 0", slot);
    end
    @(posedge clk); #1;
    if (slot == 0) s0_vld = 0; else s1_vld = 0;
    @(negedge clk);
    total++;
    if (((slot == 0) ? s0_rdy : s1_rdy) !== 1'b0) begin
      bad++; $display("FAIL rdy_width slot=%0d rdy still 1 after grant, required 0", slot);
    end
    if (code == 2'b00) begin
      total++;
      if ({in1, in2, in5, disp_vld} !== 4'b0 || credit !== 3'(ref_credit)) begin
        bad++;
        $display("FAIL null_coin in=%b disp_vld=%b credit=%0d, required 0 0 %0d",
                 {in1, in2, in5}, disp_vld, credit, ref_credit);
      end
      return;
    end
    exp_in = (code == 2'b01) ? 3'b100 : (code == 2'b10) ? 3'b010 : 3'b001;
    total++;
    if ({in1, in2, in5} !== exp_in) begin
      bad++; $display("FAIL issue_pulse in1/2/5=%b, required %b", {in1, in2, in5}, exp_in);
    end
    @(negedge clk);
    total++;
    if ({in1, in2, in5} !== 3'b000) begin
      bad++; $display("FAIL pulse_width in1/2/5=%b in SAMPLE, required 000", {in1, in2, in5});
    end
    model_coin(coin_val(code), t_soda, t_chg);
    rep_chg = vm_fault ? 2 : t_chg;
    if (rep_chg != t_chg) ref_err = 1;
    disp = t_soda || (rep_chg != 0);
    @(negedge clk);
    total++;
    if (credit !== 3'(ref_credit)) begin
      bad++; $display("FAIL credit got=%0d, required %0d", credit, ref_credit);
    end
    total++;
    if (err !== ref_err) begin
      bad++; $display("FAIL err got=%b, required %b", err, ref_err);
    end
    total++;
    if (disp_vld !== disp) begin
      bad++; $display("FAIL disp_vld got=%b, required %b", disp_vld, disp);
    end
    if (disp) begin
      total++;
      if (disp_soda !== t_soda || disp_chg !== 3'(rep_chg)) begin
        bad++; $display("FAIL disp_data soda=%b chg=%0d, required %b %0d",
                        disp_soda, disp_chg, t_soda, rep_chg);
      end
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        total++;
        if (disp_vld !== 1'b1 || disp_soda !== t_soda || disp_chg !== 3'(rep_chg) ||
            s0_rdy !== 1'b0 || s1_rdy !== 1'b0) begin
          bad++;
          $display("FAIL disp_stall cyc=%0d vld=%b soda=%b chg=%0d rdy=%b%b, required 1 %b %0d 00",
                   s, disp_vld, disp_soda, disp_chg, s1_rdy, s0_rdy, t_soda, rep_chg);
        end
      end
      @(posedge clk); #1;
      disp_rdy = 1;
      @(posedge clk); #1;
      disp_rdy = 0;
      if (t_soda && ref_cnt < MAXCNT) ref_cnt++;
      @(negedge clk);
      total++;
      if (disp_vld !== 1'b0) begin
        bad++; $display("FAIL disp_release disp_vld=%b after handshake, required 0", disp_vld);
      end
    end
    total++;
    if (vend_cnt !== CNT_W'(ref_cnt)) begin
      bad++; $display("FAIL vend_cnt got=%0d, required %0d", vend_cnt, ref_cnt);
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst = 1; vm_clear = 1; s0_vld = 1; s1_vld = 1; s0_coin = 2'b01; s1_coin = 2'b11;
    @(negedge clk);
    total++;
    if ({s0_rdy, s1_rdy, in1, in2, in5, disp_vld, disp_soda, disp_chg, credit, vend_cnt, err}
        !== '0) begin
      bad++;
      $display("FAIL reset_outputs rdy=%b%b in=%b%b%b dv=%b ds=%b dc=%0d cr=%0d vc=%0d err=%b, required all 0",
               s1_rdy, s0_rdy, in1, in2, in5, disp_vld, disp_soda, disp_chg, credit, vend_cnt, err);
    end
    apply_reset();
  endtask

  task automatic test_five_ones();
    apply_reset();
    for (int i = 0; i < 5; i++) run_coin(0, 2'b01, 0);
    total++;
    if (vend_cnt !== CNT_W'(1) || err !== 1'b0) begin
      bad++; $display("FAIL five_ones vend_cnt=%0d err=%b, required 1 0", vend_cnt, err);
    end
  endtask

  task automatic test_change();
    run_coin(0, 2'b01, 0);
    run_coin(0, 2'b10, 0);
    run_coin(1, 2'b11, 1);
  endtask

  task automatic test_rr();
    int n, cyc, last;
    bit t_soda;
    int t_chg;
    apply_reset();
    @(posedge clk); #1;
    s0_vld = 1; s1_vld = 1; s0_coin = 2'b01; s1_coin = 2'b01;
    n = 0; cyc = 0; last = 0;
    for (int i = 0; i < 40 && n < 4; i++) begin
      @(negedge clk); cyc++;
      if (s0_rdy || s1_rdy) begin
        total++;
        if ((s0_rdy ^ s1_rdy) !== 1'b1 || s1_rdy !== 1'(n % 2)) begin
          bad++; $display("FAIL rr_grant n=%0d rdy=%b%b, required slot %0d", n, s1_rdy, s0_rdy, n % 2);
        end
        if (n > 0) begin
          total++;
          if (cyc - last != 3) begin
            bad++; $display("FAIL rr_period n=%0d period=%0d, required 3", n, cyc - last);
          end
        end
        last = cyc;
        model_coin(1, t_soda, t_chg);
        n++;
        @(negedge clk); cyc++;
        total++;
        if ({s0_rdy, s1_rdy} !== 2'b00) begin
          bad++; $display("FAIL rr_width n=%0d rdy=%b%b, required 00", n, s1_rdy, s0_rdy);
        end
      end
    end
    @(posedge clk); #1;
    s0_vld = 0; s1_vld = 0;
    total++;
    if (n != 4) begin
      bad++; $display("FAIL rr_count grants=%0d, required 4", n);
    end
    repeat (3) @(negedge clk);
    total++;
    if (credit !== 3'(ref_credit)) begin
      bad++; $display("FAIL rr_credit got=%0d, required %0d", credit, ref_credit);
    end
  endtask

  task automatic test_stall();
    apply_reset();
    s1_vld = 1; s1_coin = 2'b00;
    run_coin(0, 2'b11, 10);
    total++;
    if (s1_rdy !== 1'b1) begin
      bad++; $display("FAIL stall_accept s1_rdy=%b after handshake, required 1", s1_rdy);
    end
    @(posedge clk); #1;
    s1_vld = 0;
    @(negedge clk);
    total++;
    if ({in1, in2, in5} !== 3'b000 || credit !== 3'(ref_credit)) begin
      bad++; $display("FAIL stall_null in=%b credit=%0d, required 000 %0d",
                      {in1, in2, in5}, credit, ref_credit);
    end
  endtask

  task automatic test_err();
    apply_reset();
    vm_fault = 1;
    run_coin(0, 2'b01, 2);
    vm_fault = 0;
    run_coin(1, 2'b00, 0);
    run_coin(0, 2'b10, 0);
    repeat (3) @(negedge clk);
    total++;
    if (err !== 1'b1 || credit !== 3'(ref_credit)) begin
      bad++; $display("FAIL err_sticky err=%b credit=%0d, required 1 %0d", err, credit, ref_credit);
    end
  endtask

  task automatic test_rst_disp();
    apply_reset();
    run_coin(0, 2'b10, 0);
    @(posedge clk); #1;
    s0_vld = 1; s0_coin = 2'b11;
    @(negedge clk);
    @(posedge clk); #1;
    s0_vld = 0;
    repeat (3) @(negedge clk);
    total++;
    if (disp_vld !== 1'b1 || disp_chg !== 3'd2) begin
      bad++; $display("FAIL rst_pre disp_vld=%b chg=%0d, required 1 2", disp_vld, disp_chg);
    end
    rst = 1; s0_vld = 1; s0_coin = 2'b01;
    #1;
    total++;
    if ({s0_rdy, s1_rdy, in1, in2, in5, disp_vld, disp_soda, disp_chg, credit, vend_cnt, err}
        !== '0) begin
      bad++;
      $display("FAIL rst_mid dv=%b ds=%b dc=%0d cr=%0d vc=%0d rdy=%b, required all 0",
               disp_vld, disp_soda, disp_chg, credit, vend_cnt, s0_rdy);
    end
    @(posedge clk); #1;
    rst = 0; s0_vld = 0;
    ref_credit = 0; ref_cnt = 0; ref_err = 0;
    @(negedge clk);
    total++;
    if (disp_vld !== 1'b0 || vend_cnt !== '0 || credit !== 3'd0) begin
      bad++; $display("FAIL rst_after dv=%b vc=%0d cr=%0d, required 0 0 0", disp_vld, vend_cnt, credit);
    end
    run_coin(1, 2'b01, 0);
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 40; i++) begin
      run_coin(int'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    for (int i = 0; i < MAXCNT + 5; i++) run_coin(i % 2, 2'b11, 0);
    total++;
    if (vend_cnt !== CNT_W'(MAXCNT)) begin
      bad++; $display("FAIL saturation vend_cnt=%0d, required %0d", vend_cnt, MAXCNT);
    end
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1; vm_clear = 1; vm_fault = 0; vm_credit = 0;
    s0_vld = 0; s1_vld = 0; s0_coin = 0; s1_coin = 0; disp_rdy = 0;
    ref_credit = 0; ref_cnt = 0; ref_err = 0;
    test_reset();
    test_five_ones();
    test_change();
    test_rr();
    test_stall();
    test_err();
    test_rst_disp();
    test_random();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
